// File: rtl/prog_loader_pkg.sv
// Shared constants for the program loader: FSM state encoding and stream framing.
// Optional checksum trailer is enabled with PROG_LOADER_CHECKSUM_EN.
package prog_loader_pkg;

   localparam int unsigned STATE_W        = 3;
   localparam int unsigned BYTES_PER_WORD = 4;
   localparam int unsigned LEN_BYTES      = 2;
   localparam int unsigned LEN_W          = 8 * LEN_BYTES;
   localparam int unsigned WORD_W         = 8 * BYTES_PER_WORD;
   localparam int unsigned LANE_W         = $clog2(BYTES_PER_WORD);

   localparam logic [STATE_W-1:0] IDLE   = 3'd0;
   localparam logic [STATE_W-1:0] LEN_LO = 3'd1;
   localparam logic [STATE_W-1:0] LEN_HI = 3'd2;
   localparam logic [STATE_W-1:0] DATA   = 3'd3;
   localparam logic [STATE_W-1:0] WRITE  = 3'd4;
   localparam logic [STATE_W-1:0] CHECK  = 3'd5;
   localparam logic [STATE_W-1:0] DONE   = 3'd6;
   localparam logic [STATE_W-1:0] ERR    = 3'd7;

endpackage

// File: rtl/prog_loader_word_assembler.sv
// Packs little-endian stream bytes into a 32-bit word; full_c_o flags the byte
// that completes the word.
module word_assembler
   import prog_loader_pkg::*;
(
   input  logic              clk,
   input  logic              reset,
   input  logic              clear_i,
   input  logic              load_i,
   input  logic [7:0]        byte_i,
   output logic [WORD_W-1:0] word_o,
   output logic              full_c_o
);

   logic [LANE_W-1:0] lane_q, lane_d;
   logic [WORD_W-1:0] word_q, word_d;

   always_comb begin
      lane_d = lane_q;
      word_d = word_q;
      if (clear_i) begin
         lane_d = '0;
      end else if (load_i) begin
         word_d[{lane_q, 3'b000} +: 8] = byte_i;
         lane_d = lane_q + LANE_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         lane_q <= '0;
         word_q <= '0;
      end else begin
         lane_q <= lane_d;
         word_q <= word_d;
      end
   end

   assign word_o   = word_q;
   assign full_c_o = load_i && !clear_i && (lane_q == LANE_W'(BYTES_PER_WORD - 1));

endmodule

// File: rtl/prog_loader.sv
// Length-prefixed byte-stream loader: writes N words to imem, then releases core reset.
// Define PROG_LOADER_CHECKSUM_EN to require a trailing XOR checksum byte.
module prog_loader
   import prog_loader_pkg::*;
#(
   parameter int unsigned ADDR_W = 8,
   parameter int unsigned DEPTH  = 256
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic              byte_valid,
   input  logic [7:0]        byte_data,
   output logic              byte_ready,
   output logic              imem_we,
   output logic [ADDR_W-1:0] imem_addr,
   output logic [31:0]       imem_wdata,
   output logic              core_reset,
   output logic              done,
   output logic              error
);

   localparam int unsigned CNT_W = ADDR_W + 1;

`ifdef PROG_LOADER_CHECKSUM_EN
   localparam logic [STATE_W-1:0] LAST_NEXT = CHECK;
`else
   localparam logic [STATE_W-1:0] LAST_NEXT = DONE;
`endif

   logic [STATE_W-1:0] state_q, state_d;
   logic [LEN_W-1:0]   len_q, len_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               ready_q, ready_d;
   logic               we_q, we_d;
   logic               core_reset_q, core_reset_d;
   logic               done_q, done_d;
   logic               error_q, error_d;
   logic               xfer_c;
   logic               asm_clear_c, asm_load_c, asm_full_c;
   logic [LEN_W-1:0]   len_full_c;

   assign xfer_c     = byte_valid && ready_q;
   assign len_full_c = {byte_data, len_q[7:0]};

`ifdef PROG_LOADER_CHECKSUM_EN
   logic [7:0] csum_q, csum_d;

   // Running XOR over every accepted byte since leaving IDLE.
   always_comb begin
      csum_d = csum_q;
      if (state_q == IDLE)  csum_d = '0;
      else if (xfer_c)      csum_d = csum_q ^ byte_data;
   end

   always_ff @(posedge clk) begin
      if (reset) csum_q <= '0;
      else       csum_q <= csum_d;
   end
`endif

   always_comb begin
      state_d     = state_q;
      len_d       = len_q;
      cnt_d       = cnt_q;
      asm_clear_c = 1'b0;
      asm_load_c  = 1'b0;
      case (state_q)
         IDLE: begin
            cnt_d       = '0;
            len_d       = '0;
            asm_clear_c = 1'b1;
            if (start) state_d = LEN_LO;
         end
         LEN_LO: begin
            if (xfer_c) begin
               len_d   = {len_q[15:8], byte_data};
               state_d = LEN_HI;
            end
         end
         LEN_HI: begin
            if (xfer_c) begin
               len_d = len_full_c;
               if (len_full_c == '0)                      state_d = LAST_NEXT;
               else if (32'(len_full_c) > 32'(DEPTH))     state_d = ERR;
               else                                       state_d = DATA;
            end
         end
         DATA: begin
            asm_load_c = xfer_c;
            if (asm_full_c) state_d = WRITE;
         end
         WRITE: begin
            cnt_d   = cnt_q + CNT_W'(1);
            state_d = (LEN_W'(cnt_d) == len_q) ? LAST_NEXT : DATA;
         end
`ifdef PROG_LOADER_CHECKSUM_EN
         CHECK: begin
            if (xfer_c) state_d = (byte_data == csum_q) ? DONE : ERR;
         end
`endif
         DONE, ERR: state_d = state_q;
         default:   state_d = IDLE;
      endcase
   end

   // Outputs are registered from the next state so they line up with state_q.
   always_comb begin
      ready_d      = (state_d == LEN_LO) || (state_d == LEN_HI) ||
                     (state_d == DATA)   || (state_d == CHECK);
      we_d         = (state_d == WRITE);
      core_reset_d = (state_d != DONE);
      done_d       = (state_d == DONE);
      error_d      = (state_d == ERR);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= IDLE;
         len_q        <= '0;
         cnt_q        <= '0;
         ready_q      <= 1'b0;
         we_q         <= 1'b0;
         core_reset_q <= 1'b1;
         done_q       <= 1'b0;
         error_q      <= 1'b0;
      end else begin
         state_q      <= state_d;
         len_q        <= len_d;
         cnt_q        <= cnt_d;
         ready_q      <= ready_d;
         we_q         <= we_d;
         core_reset_q <= core_reset_d;
         done_q       <= done_d;
         error_q      <= error_d;
      end
   end

   word_assembler u_asm (
      .clk      (clk),
      .reset    (reset),
      .clear_i  (asm_clear_c),
      .load_i   (asm_load_c),
      .byte_i   (byte_data),
      .word_o   (imem_wdata),
      .full_c_o (asm_full_c)
   );

   assign byte_ready = ready_q;
   assign imem_we    = we_q;
   assign imem_addr  = cnt_q[ADDR_W-1:0];
   assign core_reset = core_reset_q;
   assign done       = done_q;
   assign error      = error_q;

endmodule

// File: tb/tb_prog_loader.sv
// Bench for prog_loader: stream-level model predicts writes and final outcome,
// a negedge monitor checks every write and the output invariants.
module tb_prog_loader;

   localparam int unsigned ADDR_W = 8;
   localparam int unsigned DEPTH  = 256;

   logic              clk = 1'b0;
   logic              reset;
   logic              start;
   logic              byte_valid;
   logic [7:0]        byte_data;
   logic              byte_ready;
   logic              imem_we;
   logic [ADDR_W-1:0] imem_addr;
   logic [31:0]       imem_wdata;
   logic              core_reset;
   logic              done;
   logic              error;

   prog_loader #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
      .clk        (clk),
      .reset      (reset),
      .start      (start),
      .byte_valid (byte_valid),
      .byte_data  (byte_data),
      .byte_ready (byte_ready),
      .imem_we    (imem_we),
      .imem_addr  (imem_addr),
      .imem_wdata (imem_wdata),
      .core_reset (core_reset),
      .done       (done),
      .error      (error)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;
   int last_we = -10;
   logic done_prev = 1'b0;

   logic [7:0]  stim[$];
   int          exp_addr[$];
   logic [31:0] exp_data[$];
   int          exp_end;      // 0 none, 1 done, 2 error
   int          exp_n;
   int          log_addr[$];
   logic [31:0] log_data[$];

   always @(posedge clk) cyc++;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
      total++;
      if (act !== want) begin
         bad++;
         $display("FAIL %s: got %h want %h (cycle %0d)", name, act, want, cyc);
      end
   endtask

   // Predict writes and outcome straight from the stream rules.
   task automatic model_load();
      int n;
      logic [7:0] x;
      exp_addr.delete();
      exp_data.delete();
      n = int'(stim[0]) + 256 * int'(stim[1]);
      exp_n = 0;
      if (n > int'(DEPTH)) begin
         exp_end = 2;
      end else begin
         exp_end = 1;
         exp_n   = n;
         for (int w = 0; w < n; w++) begin
            exp_addr.push_back(w);
            exp_data.push_back({stim[2+4*w+3], stim[2+4*w+2], stim[2+4*w+1], stim[2+4*w]});
         end
`ifdef PROG_LOADER_CHECKSUM_EN
         x = 8'h00;
         for (int i = 0; i < stim.size() - 1; i++) x = x ^ stim[i];
         if (stim[stim.size()-1] != x) exp_end = 2;
`else
         x = 8'h00;
`endif
      end
   endtask

   task automatic add_csum(input logic [7:0] flip);
`ifdef PROG_LOADER_CHECKSUM_EN
      logic [7:0] x = 8'h00;
      foreach (stim[i]) x = x ^ stim[i];
      stim.push_back(x ^ flip);
`else
      if (flip != 8'h00) stim.push_back(8'h00);
      else stim.push_back(8'h00);
      void'(stim.pop_back());
`endif
   endtask

   task automatic set_scn1();
      stim = '{8'h02, 8'h00, 8'h13, 8'h00, 8'h10, 8'h00, 8'h93, 8'h00, 8'h20, 8'h00};
   endtask

   task automatic send_byte(input logic [7:0] b);
      int budget = 50;
      byte_valid = 1'b1;
      byte_data  = b;
      while (!byte_ready && budget > 0) begin
         @(negedge clk);
         budget--;
      end
      if (budget == 0) begin
         total++;
         bad++;
         $display("FAIL byte_accept_timeout: byte %h never accepted", b);
      end
      @(negedge clk);
   endtask

   task automatic drive_stream(input int count, input int max_gap);
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      for (int i = 0; i < count; i++) begin
         send_byte(stim[i]);
         if (max_gap > 0) begin
            byte_valid = 1'b0;
            byte_data  = 8'hxx;
            repeat ($urandom_range(max_gap, 1)) @(negedge clk);
         end
      end
      byte_valid = 1'b0;
   endtask

   task automatic wait_end();
      int budget = 100;
      while (!(done || error) && budget > 0) begin
         @(negedge clk);
         budget--;
      end
      if (budget == 0) begin
         total++;
         bad++;
         $display("FAIL end_timeout: done=%b error=%b", done, error);
      end
      chk("end_done", 32'(done), 32'(exp_end == 1));
      chk("end_error", 32'(error), 32'(exp_end == 2));
      chk("end_core_reset", 32'(core_reset), 32'(exp_end != 1));
      chk("writes_pending", 32'(exp_addr.size()), 32'd0);
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      chk("rst_ready", 32'(byte_ready), 32'd0);
      chk("rst_we", 32'(imem_we), 32'd0);
      chk("rst_addr", 32'(imem_addr), 32'd0);
      chk("rst_wdata", imem_wdata, 32'd0);
      chk("rst_core_reset", 32'(core_reset), 32'd1);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_error", 32'(error), 32'd0);
      reset = 1'b0;
      exp_addr.delete();
      exp_data.delete();
      log_addr.delete();
      log_data.delete();
      exp_n = 0;
   endtask

   task automatic chk_scn1_log();
      chk("scn1_nwrites", 32'(log_addr.size()), 32'd2);
      if (log_addr.size() == 2) begin
         chk("scn1_addr0", 32'(log_addr[0]), 32'd0);
         chk("scn1_data0", log_data[0], 32'h00100013);
         chk("scn1_addr1", 32'(log_addr[1]), 32'd1);
         chk("scn1_data1", log_data[1], 32'h00200093);
      end
   endtask

   // Monitor: every write against the model, plus standing output invariants.
   always @(negedge clk) begin
      if (imem_we) begin
         log_addr.push_back(int'(imem_addr));
         log_data.push_back(imem_wdata);
         last_we = cyc;
         if (exp_addr.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_write: addr %h data %h", imem_addr, imem_wdata);
         end else begin
            chk("wr_addr", 32'(imem_addr), 32'(exp_addr.pop_front()));
            chk("wr_data", imem_wdata, exp_data.pop_front());
         end
      end
      chk("core_reset_vs_done", 32'(core_reset), 32'(!done));
      if (done || error) chk("ready_when_halted", 32'(byte_ready), 32'd0);
`ifndef PROG_LOADER_CHECKSUM_EN
      if (done && !done_prev && exp_n > 0) chk("done_latency", 32'(cyc - last_we), 32'd1);
`endif
      done_prev <= done;
   end

   initial begin
      reset      = 1'b1;
      start      = 1'b0;
      byte_valid = 1'b0;
      byte_data  = 8'h00;
      exp_n      = 0;
      exp_end    = 0;
      repeat (2) @(negedge clk);
      do_reset();

      // Scenario 1: two words back to back.
      set_scn1();
      add_csum(8'h00);
      model_load();
      drive_stream(stim.size(), 0);
      wait_end();
      chk_scn1_log();
      // Extra bytes and start in DONE are ignored.
      byte_valid = 1'b1;
      byte_data  = 8'h55;
      start      = 1'b1;
      repeat (5) @(negedge clk);
      byte_valid = 1'b0;
      start      = 1'b0;
      chk("done_hold", 32'(done), 32'd1);
      chk("done_no_extra_write", 32'(log_addr.size()), 32'd2);

      // Scenario 2: N=0.
      do_reset();
      stim = '{8'h00, 8'h00};
      add_csum(8'h00);
      model_load();
      drive_stream(stim.size(), 0);
      wait_end();
      chk("n0_nwrites", 32'(log_addr.size()), 32'd0);

      // Scenario 3: N=DEPTH+1 aborts.
      do_reset();
      stim = '{8'h01, 8'h01};
      model_load();
      drive_stream(stim.size(), 0);
      wait_end();
      repeat (3) @(negedge clk);
      chk("err_hold", 32'(error), 32'd1);
      chk("err_nwrites", 32'(log_addr.size()), 32'd0);

      // Scenario 4: gaps of 1-3 idle cycles between bytes.
      do_reset();
      set_scn1();
      add_csum(8'h00);
      model_load();
      drive_stream(stim.size(), 3);
      wait_end();
      chk_scn1_log();

      // Scenario 5: reset after two data bytes of word 1, then a fresh load.
      do_reset();
      set_scn1();
      add_csum(8'h00);
      model_load();
      drive_stream(8, 0);
      do_reset();
      set_scn1();
      add_csum(8'h00);
      model_load();
      drive_stream(stim.size(), 0);
      wait_end();
      chk_scn1_log();

      // Boundary: N=DEPTH fills memory exactly.
      do_reset();
      stim = '{8'h00, 8'h01};
      for (int w = 0; w < int'(DEPTH); w++) begin
         stim.push_back(8'(w + 3));
         stim.push_back(8'(~w));
         stim.push_back(8'h5A);
         stim.push_back(8'(w));
      end
      add_csum(8'h00);
      model_load();
      drive_stream(stim.size(), 0);
      wait_end();
      chk("full_nwrites", 32'(log_addr.size()), 32'(DEPTH));
      if (log_addr.size() == int'(DEPTH)) begin
         chk("full_last_addr", 32'(log_addr[DEPTH-1]), 32'(DEPTH - 1));
         chk("full_last_data", log_data[DEPTH-1], 32'hFF5A0002);
      end

`ifdef PROG_LOADER_CHECKSUM_EN
      // Wrong checksum: words still written, but load aborts.
      do_reset();
      set_scn1();
      add_csum(8'h07);
      model_load();
      drive_stream(stim.size(), 0);
      wait_end();
      chk_scn1_log();
`endif

      repeat (2) @(negedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
